// File: rtl/cells_frame_scheduler.sv
// Frame scheduler for the cell-array scan controller: queues cell-state frames and
// holds each one on cells_state for a programmed number of completed scan sweeps.
module cells_frame_scheduler #(
  parameter int          DEPTH    = 4,
  parameter int          CNT_W    = 8,
  parameter logic [31:0] CCR0_RST = 32'd100,
  parameter logic [31:0] CCR1_RST = 32'd200
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [15:0]                frame_data,
  input  logic [CNT_W-1:0]           frame_repeat,
  input  logic                       frame_valid,
  output logic                       frame_ready,
  input  logic [31:0]                cfg_ccr0,
  input  logic [31:0]                cfg_ccr1,
  input  logic                       cfg_wr,
  input  logic                       run,
  input  logic                       update_done,
  output logic [15:0]                cells_state,
  output logic                       system_enable_n,
  output logic                       enable_sn,
  output logic [31:0]                ccr0,
  output logic [31:0]                ccr1,
  output logic                       frame_done,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

  state_t state, state_nx;

  logic [15:0]      mem_data [DEPTH];
  logic [CNT_W-1:0] mem_rep  [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level_nx;
  logic             push, pop;

  logic             update_done_p1;
  logic             ud_rise;
  logic [CNT_W-1:0] sweep_cnt, sweep_inc, target;
  logic [31:0]      pend_ccr0, pend_ccr1;

  // Drive window can never exceed the slot period it lives in.
  function automatic logic [31:0] clamp_ccr0(input logic [31:0] win, input logic [31:0] period);
    clamp_ccr0 = (win > period) ? period : win;
  endfunction

  function automatic logic [CNT_W-1:0] repeat_floor1(input logic [CNT_W-1:0] rep);
    repeat_floor1 = (rep == '0) ? CNT_W'(1) : rep;
  endfunction

  assign push      = frame_valid & frame_ready;
  assign pop       = (state == LOAD);
  assign ud_rise   = update_done & ~update_done_p1;
  assign sweep_inc = sweep_cnt + CNT_W'(1);

  always_comb begin
    level_nx = fifo_level;
    case ({push, pop})
      2'b10:   level_nx = fifo_level + LW'(1);
      2'b01:   level_nx = fifo_level - LW'(1);
      default: level_nx = fifo_level;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (run && fifo_level != '0) state_nx = LOAD;
      LOAD: state_nx = SCAN;
      SCAN: if (ud_rise && sweep_inc == target) state_nx = DONE;
      DONE: state_nx = (run && fifo_level != '0) ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Frame storage carries no reset; only pointers and level are control.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_data[wr_ptr] <= frame_data;
      mem_rep[wr_ptr]  <= frame_repeat;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_level      <= '0;
      frame_ready     <= 1'b1;
      update_done_p1  <= 1'b0;
      sweep_cnt       <= '0;
      target          <= CNT_W'(1);
      pend_ccr0       <= CCR0_RST;
      pend_ccr1       <= CCR1_RST;
      ccr0            <= CCR0_RST;
      ccr1            <= CCR1_RST;
      cells_state     <= '0;
      system_enable_n <= 1'b1;
      enable_sn       <= 1'b1;
      frame_done      <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state          <= state_nx;
      update_done_p1 <= update_done;
      fifo_level     <= level_nx;
      frame_ready    <= (level_nx < LW'(DEPTH));
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      // LOAD reads the pending timing values as they stood before this edge.
      if (state == LOAD) begin
        cells_state <= mem_data[rd_ptr];
        target      <= repeat_floor1(mem_rep[rd_ptr]);
        sweep_cnt   <= '0;
        ccr1        <= pend_ccr1;
        ccr0        <= clamp_ccr0(pend_ccr0, pend_ccr1);
      end else if (state == SCAN && ud_rise) begin
        sweep_cnt <= sweep_inc;
      end

      if (cfg_wr) begin
        pend_ccr0 <= cfg_ccr0;
        pend_ccr1 <= cfg_ccr1;
      end

      // Outputs follow the state being entered so they line up with it.
      system_enable_n <= (state_nx == IDLE) || (state_nx == LOAD);
      enable_sn       <= (state_nx == IDLE);
      frame_done      <= (state_nx == DONE);
      busy            <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_cells_frame_scheduler.sv
// Randomised bench for cells_frame_scheduler with a queue-based reference model,
// a reactive scan-controller stand-in, and a few literal expectations.
module tb_cells_frame_scheduler;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_SCAN = 2;
  localparam int M_DONE = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [15:0]      fd = '0;
  logic [CNT_W-1:0] fr = '0;
  logic             fv = 1'b0;
  logic [31:0]      c0 = '0, c1 = '0;
  logic             cfg_wr = 1'b0;
  logic             run = 1'b0;
  logic             ud = 1'b0;

  logic             frame_ready, system_enable_n, enable_sn, frame_done, busy;
  logic [15:0]      cells_state;
  logic [31:0]      ccr0, ccr1;
  logic [LW-1:0]    fifo_level;

  cells_frame_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W), .CCR0_RST(32'd100), .CCR1_RST(32'd200)) dut (
    .clock(clk), .reset(rst), .frame_data(fd), .frame_repeat(fr), .frame_valid(fv),
    .frame_ready(frame_ready), .cfg_ccr0(c0), .cfg_ccr1(c1), .cfg_wr(cfg_wr), .run(run),
    .update_done(ud), .cells_state(cells_state), .system_enable_n(system_enable_n),
    .enable_sn(enable_sn), .ccr0(ccr0), .ccr1(ccr1), .frame_done(frame_done), .busy(busy),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scan-controller stand-in: one update_done pulse every gen_period enabled cycles.
  int gen_period = 4;
  int gcnt = 0;
  always @(negedge clk) begin
    if (system_enable_n !== 1'b0) begin
      gcnt = 0;
      ud = 1'b0;
    end else begin
      gcnt++;
      ud = ((gcnt % gen_period) == 0);
    end
  end

  // Reference model
  typedef struct { logic [15:0] d; int rep; } frame_t;
  frame_t      mq[$];
  frame_t      head;
  int          m_phase = M_IDLE, nph, sz;
  logic [15:0] m_cells = '0;
  int          m_sweeps = 0, m_target = 1;
  logic [31:0] m_ccr0 = 32'd100, m_ccr1 = 32'd200, m_p0 = 32'd100, m_p1 = 32'd200;
  bit          m_udprev = 1'b0, rise, acc;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_phase = M_IDLE; m_cells = '0; m_sweeps = 0; m_target = 1; m_udprev = 1'b0;
      m_ccr0 = 32'd100; m_ccr1 = 32'd200; m_p0 = 32'd100; m_p1 = 32'd200;
    end else begin
      sz   = mq.size();
      acc  = fv && (sz < DEPTH);
      rise = ud && !m_udprev;
      m_udprev = ud;
      nph  = m_phase;
      case (m_phase)
        M_IDLE: if (run && sz != 0) nph = M_LOAD;
        M_LOAD: begin
          head = mq.pop_front();
          m_cells  = head.d;
          m_target = (head.rep == 0) ? 1 : head.rep;
          m_sweeps = 0;
          m_ccr1   = m_p1;
          m_ccr0   = (m_p0 > m_p1) ? m_p1 : m_p0;
          nph = M_SCAN;
        end
        M_SCAN: if (rise) begin
          m_sweeps++;
          if (m_sweeps == m_target) nph = M_DONE;
        end
        default: nph = (run && sz != 0) ? M_LOAD : M_IDLE;
      endcase
      if (cfg_wr) begin m_p0 = c0; m_p1 = c1; end
      if (acc) mq.push_back('{d: fd, rep: int'(fr)});
      m_phase = nph;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cells_state", cells_state, m_cells);
      check("system_enable_n", system_enable_n, (m_phase == M_IDLE || m_phase == M_LOAD));
      check("enable_sn", enable_sn, (m_phase == M_IDLE));
      check("frame_done", frame_done, (m_phase == M_DONE));
      check("busy", busy, (m_phase != M_IDLE));
      check("ccr0", ccr0, m_ccr0);
      check("ccr1", ccr1, m_ccr1);
      check("fifo_level", fifo_level, mq.size());
      check("frame_ready", frame_ready, (mq.size() < DEPTH));
    end
  end

  int          n_done = 0;
  logic [15:0] done_q[$];
  always @(negedge clk) begin
    if (chk_en && frame_done === 1'b1) begin
      n_done++;
      done_q.push_back(cells_state);
    end
  end

  task automatic push_one(input logic [15:0] d, input logic [CNT_W-1:0] r);
    @(negedge clk);
    fv = 1'b1; fd = d; fr = r;
    @(negedge clk);
    fv = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 600 && busy !== 1'b0; k++) @(negedge clk);
    if (busy !== 1'b0) check("idle_timeout", busy, 32'd0);
  endtask

  task automatic wait_scan();
    for (int k = 0; k < 600 && !(busy === 1'b1 && system_enable_n === 1'b0); k++) @(negedge clk);
    if (!(busy === 1'b1 && system_enable_n === 1'b0)) check("scan_timeout", busy, 32'd1);
  endtask

  int d0;

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_cells", cells_state, 32'h0);
    check("rst_ccr0", ccr0, 32'd100);
    check("rst_ccr1", ccr1, 32'd200);
    check("rst_sen_n", system_enable_n, 32'd1);
    check("rst_level", fifo_level, 32'd0);
    rst = 1'b0;

    // Single frame, two sweeps
    run = 1'b1;
    d0 = n_done;
    push_one(16'h02A5, 8'd2);
    @(negedge clk);
    check("t1_load_busy", busy, 32'd1);
    check("t1_load_sen_n", system_enable_n, 32'd1);
    @(negedge clk);
    check("t1_cells", cells_state, 32'h02A5);
    wait_idle();
    check("t1_done_count", n_done - d0, 32'd1);
    check("t1_idle_sen_n", system_enable_n, 32'd1);
    check("t1_idle_en_sn", enable_sn, 32'd1);

    // Overfill with run low
    run = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      @(negedge clk);
      fv = 1'b1; fd = 16'hA000 + 16'(i); fr = 8'd1;
    end
    @(negedge clk);
    fv = 1'b0;
    check("t2_level", fifo_level, 32'd4);
    check("t2_ready", frame_ready, 32'd0);

    // Three back-to-back frames
    do_reset();
    push_one(16'h0111, 8'd1);
    push_one(16'h0222, 8'd1);
    push_one(16'h0333, 8'd1);
    done_q.delete();
    d0 = n_done;
    run = 1'b1;
    repeat (3) @(negedge clk);
    wait_idle();
    check("t3_done_count", n_done - d0, 32'd3);
    if (done_q.size() == 3) begin
      check("t3_order0", done_q[0], 32'h0111);
      check("t3_order1", done_q[1], 32'h0222);
      check("t3_order2", done_q[2], 32'h0333);
    end else check("t3_order_len", done_q.size(), 32'd3);

    // Timing write in SCAN applies at next LOAD, clamped
    push_one(16'h0F0F, 8'd2);
    wait_scan();
    cfg_wr = 1'b1; c0 = 32'd50; c1 = 32'd40;
    @(negedge clk);
    cfg_wr = 1'b0;
    check("t4_ccr0_hold", ccr0, 32'd100);
    check("t4_ccr1_hold", ccr1, 32'd200);
    wait_idle();
    push_one(16'h00F0, 8'd1);
    wait_scan();
    check("t4_ccr0_clamp", ccr0, 32'd40);
    check("t4_ccr1_new", ccr1, 32'd40);
    wait_idle();

    // Repeat of zero means one sweep
    d0 = n_done;
    push_one(16'h1234, 8'd0);
    repeat (3) @(negedge clk);
    wait_idle();
    check("t5_rep0_done", n_done - d0, 32'd1);

    // Dropping run mid-SCAN finishes the current frame only
    run = 1'b0;
    push_one(16'h2001, 8'd2);
    push_one(16'h2002, 8'd1);
    push_one(16'h2003, 8'd1);
    run = 1'b1;
    wait_scan();
    run = 1'b0;
    wait_idle();
    check("t5_level_after_drop", fifo_level, 32'd2);

    // Reset during SCAN
    run = 1'b1;
    wait_scan();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_cells", cells_state, 32'h0);
    check("t6_level", fifo_level, 32'd0);
    check("t6_frame_done", frame_done, 32'd0);
    check("t6_sen_n", system_enable_n, 32'd1);
    check("t6_en_sn", enable_sn, 32'd1);
    check("t6_ccr0", ccr0, 32'd100);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 250 == 0) gen_period = $urandom_range(2, 6);
      rst    = ($urandom_range(0, 499) == 0);
      fv     = ($urandom_range(0, 2) == 0);
      fd     = 16'($urandom);
      fr     = 8'($urandom_range(0, 3));
      run    = ($urandom_range(0, 9) != 0);
      cfg_wr = ($urandom_range(0, 29) == 0);
      c0     = $urandom_range(0, 300);
      c1     = $urandom_range(0, 300);
    end
    @(negedge clk);
    rst = 1'b0; fv = 1'b0; cfg_wr = 1'b0; run = 1'b0;
    repeat (2) @(negedge clk);
    wait_idle();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
